// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: requests one word per PC, buffers it for decode, advances on handshake.
// Optional macro FETCH_ADEL_EN turns on fetch address-error detection (misaligned / out of range).
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] IMEM_BASE = 32'h0000_3000,
  parameter logic [31:0] IMEM_TOP  = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pcn,
  output logic        if_exc
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] instr, instr_nxt;
  logic        exc, exc_nxt;
  logic        armed;
  logic        addr_err;

  // armed stays low for the partial cycle after reset release so a stale ack is never taken
`ifdef FETCH_ADEL_EN
  assign addr_err = (pc[1:0] != 2'b00) || (pc < IMEM_BASE) || (pc > IMEM_TOP);
`else
  assign addr_err = 1'b0;
`endif

  assign imem_addr = {pc[31:2], 2'b00};
  assign if_instr  = instr;
  assign if_pc     = pc;
  assign if_pcn    = pc + 32'd4;
  assign if_exc    = exc;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
    exc_nxt   = exc;
    imem_req  = 1'b0;
    if_valid  = 1'b0;
    case (state)
      FETCH: begin
        if (armed) begin
          if (addr_err) begin
            instr_nxt = '0;
            exc_nxt   = 1'b1;
            state_nxt = HOLD;
          end else begin
            imem_req = 1'b1;
            if (imem_ack) begin
              instr_nxt = imem_rdata;
              exc_nxt   = 1'b0;
              state_nxt = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if_valid = 1'b1;
        if (if_ready) begin
          pc_nxt    = npc;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
      instr <= '0;
      exc   <= 1'b0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      instr <= instr_nxt;
      exc   <= exc_nxt;
      armed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plus randomized bench for pc_fetch_unit against a transaction-level fetch model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] npc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pcn;
  logic        if_exc;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  pc_fetch_unit #(
    .RESET_PC (32'h0000_3000),
    .IMEM_BASE(32'h0000_3000),
    .IMEM_TOP (32'h0000_6FFC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .npc       (npc),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .if_pcn    (if_pcn),
    .if_exc    (if_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in FETCH one time unit after an edge; leaves in HOLD with the word buffered.
  task automatic fetch_one(input logic [31:0] pc, input int unsigned wait_cyc,
                           input logic [31:0] data);
    for (int unsigned i = 0; i < wait_cyc; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      if_ready   = 1'($urandom_range(0, 1));
      npc        = $urandom;
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, {pc[31:2], 2'b00});
      chk("wait_valid", 32'(if_valid), 32'd0);
      tick();
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    chk("ack_req", 32'(imem_req), 32'd1);
    chk("ack_addr", imem_addr, {pc[31:2], 2'b00});
    tick();
    imem_ack = 1'b0;
    if_ready = 1'b0;
    chk("hold_valid", 32'(if_valid), 32'd1);
    chk("hold_req", 32'(imem_req), 32'd0);
    chk("hold_instr", if_instr, data);
    chk("hold_pc", if_pc, pc);
    chk("hold_pcn", if_pcn, pc + 32'd4);
    chk("hold_exc", 32'(if_exc), 32'd0);
  endtask

  // Stall in HOLD with npc wandering, then hand off with the chosen next PC.
  task automatic hold_then_go(input logic [31:0] pc, input logic [31:0] data,
                              input logic exc, input int unsigned stall,
                              input logic [31:0] next);
    for (int unsigned i = 0; i < stall; i++) begin
      if_ready = 1'b0;
      npc      = $urandom;
      tick();
      chk("stall_valid", 32'(if_valid), 32'd1);
      chk("stall_instr", if_instr, data);
      chk("stall_pc", if_pc, pc);
      chk("stall_pcn", if_pcn, pc + 32'd4);
      chk("stall_exc", 32'(if_exc), 32'(exc));
    end
    if_ready = 1'b1;
    npc      = next;
    tick();
    if_ready = 1'b0;
    npc      = $urandom;
    chk("go_valid", 32'(if_valid), 32'd0);
    chk("go_pc", if_pc, next);
  endtask

  initial begin
    logic [31:0] pc_m;
    logic [31:0] data;
    logic [31:0] next;
    int unsigned t0;

    // reset held: no request, empty buffer
    tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_exc", 32'(if_exc), 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'h3000);
    #2 reset = 1'b1;
    #1 chk("rel_req_before_edge", 32'(imem_req), 32'd0);
    tick();

    // zero-wait first fetch, 1-cycle latency
    if_ready = 1'b1;
    fetch_one(32'h3000, 0, 32'hDEAD_0001);
    hold_then_go(32'h3000, 32'hDEAD_0001, 1'b0, 0, 32'h3000);

    // three-cycle ack delay, if_ready ignored while fetching
    fetch_one(32'h3000, 3, 32'hDEAD_0002);
    hold_then_go(32'h3000, 32'hDEAD_0002, 1'b0, 5, 32'h3040);
    chk("after_hold_addr", imem_addr, 32'h3040);
    chk("after_hold_req", 32'(imem_req), 32'd1);

    // sustained throughput: 4 instructions in 8 cycles
    t0 = 0;
    pc_m = 32'h3040;
    for (int unsigned k = 0; k < 4; k++) begin
      data = $urandom;
      fetch_one(pc_m, 0, data);
      hold_then_go(pc_m, data, 1'b0, 0, pc_m + 32'd4);
      pc_m = pc_m + 32'd4;
      t0 += 2;
    end
    chk("throughput_pc", if_pc, 32'h3040 + 32'(t0 / 2) * 32'd4);

`ifndef FETCH_ADEL_EN
    // pc wrap and misaligned containing-word fetch
    data = $urandom;
    fetch_one(pc_m, 0, data);
    hold_then_go(pc_m, data, 1'b0, 0, 32'hFFFF_FFFC);
    fetch_one(32'hFFFF_FFFC, 1, 32'h1234_5678);
    chk("wrap_pcn", if_pcn, 32'h0000_0000);
    hold_then_go(32'hFFFF_FFFC, 32'h1234_5678, 1'b0, 0, 32'h0000_3006);
    chk("misal_addr", imem_addr, 32'h0000_3004);
    fetch_one(32'h0000_3006, 0, 32'hCAFE_0006);
    hold_then_go(32'h0000_3006, 32'hCAFE_0006, 1'b0, 0, 32'h3000);
    pc_m = 32'h3000;
`else
    // address errors: misaligned, then above range
    data = $urandom;
    fetch_one(pc_m, 0, data);
    hold_then_go(pc_m, data, 1'b0, 0, 32'h3002);
    chk("adel_misal_req", 32'(imem_req), 32'd0);
    tick();
    chk("adel_misal_valid", 32'(if_valid), 32'd1);
    chk("adel_misal_exc", 32'(if_exc), 32'd1);
    chk("adel_misal_instr", if_instr, 32'd0);
    hold_then_go(32'h3002, 32'd0, 1'b1, 1, 32'h7000);
    chk("adel_range_req", 32'(imem_req), 32'd0);
    tick();
    chk("adel_range_valid", 32'(if_valid), 32'd1);
    chk("adel_range_exc", 32'(if_exc), 32'd1);
    chk("adel_range_instr", if_instr, 32'd0);
    hold_then_go(32'h7000, 32'd0, 1'b1, 0, 32'h3000);
    pc_m = 32'h3000;
`endif

    // reset during ack wait, stale ack after release must be ignored
    data = $urandom;
    fetch_one(pc_m, 0, data);
    hold_then_go(pc_m, data, 1'b0, 0, 32'h3100);
    chk("pre_rst_addr", imem_addr, 32'h3100);
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_pc", if_pc, 32'h3000);
    chk("mid_rst_instr", if_instr, 32'd0);
    #2;
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    tick();
    imem_ack = 1'b0;
    chk("late_ack_valid", 32'(if_valid), 32'd0);
    chk("late_ack_instr", if_instr, 32'd0);
    chk("late_ack_pc", if_pc, 32'h3000);
    chk("fresh_req", 32'(imem_req), 32'd1);
    chk("fresh_addr", imem_addr, 32'h3000);

    // reset in HOLD drops the word
    fetch_one(32'h3000, 1, 32'h5555_AAAA);
    reset = 1'b0;
    #1;
    chk("hold_rst_valid", 32'(if_valid), 32'd0);
    chk("hold_rst_instr", if_instr, 32'd0);
    #2 reset = 1'b1;
    tick();

    // randomized transactions against the model
    pc_m = 32'h3000;
    for (int unsigned k = 0; k < 24; k++) begin
      data = $urandom;
      next = 32'h3000 + 32'($urandom_range(0, 32'hFFF)) * 32'd4;
      fetch_one(pc_m, $urandom_range(0, 3), data);
      hold_then_go(pc_m, data, 1'b0, $urandom_range(0, 3), next);
      pc_m = next;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, first instruction address after reset.
REQ-002 SHALL have parameter IMEM_BASE, default 32'h0000_3000, lowest legal fetch address.
REQ-003 SHALL have parameter IMEM_TOP, default 32'h0000_6FFC, highest legal fetch address.
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port reset  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port npc  in  32  next PC chosen by the branch/jump address mux.
REQ-007 SHALL have port imem_req  out  1  instruction-memory read request.
REQ-008 SHALL have port imem_addr  out  32  word address presented with imem_req.
REQ-009 SHALL have port imem_ack  in  1  read data valid this cycle; ignored unless imem_req=1.
REQ-010 SHALL have port imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-011 SHALL have port if_valid  out  1  fetched instruction available to decode.
REQ-012 SHALL have port if_ready  in  1  decode accepts; transfer when if_valid&if_ready.
REQ-013 SHALL have port if_instr  out  32  buffered instruction.
REQ-014 SHALL have port if_pc  out  32  address of if_instr.
REQ-015 SHALL have port if_pcn  out  32  if_pc+4, fed to the branch/jump address mux.
REQ-016 SHALL have port if_exc  out  1  address-error flag for if_instr.

Function
REQ-017 SHALL implement a two-state FSM: FETCH, HOLD.
REQ-018 FETCH: imem_req=1, imem_addr=pc; on imem_ack=1 capture imem_rdata into instruction buffer, go HOLD.
REQ-019 imem_addr SHALL remain stable while imem_req=1 and imem_ack=0; no cycle limit on wait.
REQ-020 Zero-wait memory: imem_ack in the first FETCH cycle SHALL be accepted; minimum fetch-to-valid latency 1 cycle.
REQ-021 HOLD: if_valid=1, imem_req=0; if_instr/if_pc/if_pcn/if_exc stable until transfer.
REQ-022 On transfer (HOLD, if_ready=1): pc <= npc sampled that cycle, go FETCH; npc ignored in every other cycle.
REQ-023 if_ready while in FETCH SHALL have no effect.
REQ-024 if_pcn SHALL equal if_pc+32'd4 modulo 2^32; 32'hFFFF_FFFC yields 32'h0000_0000.
REQ-025 Sustained throughput with zero-wait memory and if_ready held 1: one instruction per 2 cycles.
REQ-026 if_exc SHALL be 0 whenever FETCH_ADEL_EN is undefined.

Reset
REQ-027 reset=0 SHALL immediately force: state FETCH, pc=RESET_PC, buffer=0, if_valid=0, if_exc=0.
REQ-028 During reset imem_req SHALL be 0; first request issued in the first cycle after reset returns to 1.
REQ-029 Reset mid-fetch SHALL discard the pending request; a late imem_ack after reset release with imem_req=0 is ignored.
REQ-030 Reset in HOLD SHALL drop the buffered instruction without transfer.

Configuration
REQ-031 Macro FETCH_ADEL_EN SHALL enable address-error detection.
REQ-032 Defined: in FETCH, if pc[1:0]!=0 or pc<IMEM_BASE or pc>IMEM_TOP, no request issued; next cycle go HOLD with if_instr=0, if_exc=1.
REQ-033 Undefined: no range check; imem_addr={pc[31:2],2'b00}; misaligned npc fetches the containing word.

Verification
REQ-034 Reset release, ack same cycle, if_ready=1 -> imem_addr=32'h3000, next cycle if_valid=1, if_pc=32'h3000, if_pcn=32'h3004.
REQ-035 Ack delayed 3 cycles -> imem_addr held 32'h3000 for 4 cycles, if_valid only after ack.
REQ-036 HOLD with if_ready=0 for 5 cycles, npc toggling -> outputs stable; on ready with npc=32'h3040 next imem_addr=32'h3040.
REQ-037 Wrap: force pc=32'hFFFF_FFFC (macro off) -> if_pcn=32'h0000_0000.
REQ-038 Macro on, npc=32'h3002 -> no imem_req, if_valid=1, if_exc=1, if_instr=0; npc=32'h7000 -> same.
REQ-039 Assert reset during ack wait, late ack after release -> pc=32'h3000, buffer unchanged, fresh request issued.
